// File: rtl/mem_stage_pkg.sv
// Shared control-bit positions for the EX/MEM/WB control fields of the MIPS pipeline.
package mem_stage_pkg;
  localparam int MEM_BRANCH  = 2;
  localparam int MEM_READ    = 1;
  localparam int MEM_WRITE   = 0;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  localparam int WB_W  = 2;
  localparam int MEM_W = 3;
  localparam int REG_W = 5;

  // A word access is aligned when the two byte-offset bits are zero.
  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction
endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory stage, bundled as one interface.
// No handshake: every signal is valid every cycle, and the stage never stalls.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic [WB_W-1:0]  wbEX;
  logic [MEM_W-1:0] memEX;
  logic [31:0]      brDst;
  logic             zFlag;
  logic [31:0]      alu_out;
  logic [31:0]      rtEX;
  logic [REG_W-1:0] wrDstEX;

  logic             pcSrc;
  logic [31:0]      brTgt;
  logic             alignErr;
  logic [WB_W-1:0]  wbMEM;
  logic [31:0]      rdData;
  logic [31:0]      aluMEM;
  logic [REG_W-1:0] wrDstMEM;

  modport master (
    output wbEX, memEX, brDst, zFlag, alu_out, rtEX, wrDstEX,
    input  pcSrc, brTgt, alignErr, wbMEM, rdData, aluMEM, wrDstMEM
  );

  modport slave (
    input  wbEX, memEX, brDst, zFlag, alu_out, rtEX, wrDstEX,
    output pcSrc, brTgt, alignErr, wbMEM, rdData, aluMEM, wrDstMEM
  );
endinterface

// File: rtl/mem_stage_data_mem.sv
// Word-addressed data memory: synchronous write, asynchronous read, no reset.
module data_mem #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem_q [0:(1<<AW)-1] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  // Read-during-write returns the old word; the new one shows next cycle.
  assign rdata = mem_q[addr];
endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: branch resolution, data-memory access with alignment check,
// and the MEM/WB pipeline latch.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);
  logic             rd_en, wr_en, aligned, mem_we;
  logic [AW-1:0]    word_idx;
  logic [31:0]      mem_rdata;

  logic             align_err_q, align_err_d;
  logic [WB_W-1:0]  wb_q, wb_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic [31:0]      alu_q, alu_d;
  logic [REG_W-1:0] wr_dst_q, wr_dst_d;

  assign bus.pcSrc = bus.memEX[MEM_BRANCH] & bus.zFlag;
  assign bus.brTgt = bus.brDst;

  assign rd_en    = bus.memEX[MEM_READ];
  assign wr_en    = bus.memEX[MEM_WRITE];
  assign aligned  = is_aligned(bus.alu_out);
  assign word_idx = bus.alu_out[AW+1:2];
  // A store coinciding with reset is dropped.
  assign mem_we   = wr_en & aligned & ~rst;

  data_mem #(.AW(AW)) u_data_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (word_idx),
    .wdata (bus.rtEX),
    .rdata (mem_rdata)
  );

  always_comb begin
    align_err_d = (rd_en | wr_en) & ~aligned;
    rd_data_d   = (rd_en & aligned) ? mem_rdata : 32'd0;
    wb_d        = bus.wbEX;
    alu_d       = bus.alu_out;
    wr_dst_d    = bus.wrDstEX;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      align_err_q <= 1'b0;
      wb_q        <= '0;
      rd_data_q   <= '0;
      alu_q       <= '0;
      wr_dst_q    <= '0;
    end else begin
      align_err_q <= align_err_d;
      wb_q        <= wb_d;
      rd_data_q   <= rd_data_d;
      alu_q       <= alu_d;
      wr_dst_q    <= wr_dst_d;
    end
  end

  assign bus.alignErr = align_err_q;
  assign bus.wbMEM    = wb_q;
  assign bus.rdData   = rd_data_q;
  assign bus.aluMEM   = alu_q;
  assign bus.wrDstMEM = wr_dst_q;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, branch, store/load, alignment, wrap, passthrough.
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  mem_stage_if bus ();

  mem_stage #(.AW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] wb, input logic [2:0] mem, input logic [31:0] alu,
                       input logic [31:0] rt, input logic [4:0] dst);
    bus.wbEX    = wb;
    bus.memEX   = mem;
    bus.alu_out = alu;
    bus.rtEX    = rt;
    bus.wrDstEX = dst;
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag, input logic ae, input logic [1:0] wb,
                          input logic [31:0] rd, input logic [31:0] alu, input logic [4:0] dst);
    chk({tag, ".alignErr"}, {31'd0, bus.alignErr}, {31'd0, ae});
    chk({tag, ".wbMEM"},    {30'd0, bus.wbMEM},    {30'd0, wb});
    chk({tag, ".rdData"},   bus.rdData, rd);
    chk({tag, ".aluMEM"},   bus.aluMEM, alu);
    chk({tag, ".wrDstMEM"}, {27'd0, bus.wrDstMEM}, {27'd0, dst});
  endtask

  initial begin
    bus.brDst = 32'h0;
    bus.zFlag = 1'b0;
    drive(2'b00, 3'b000, 32'h0, 32'h0, 5'd0);

    // Reset held with random inputs, including a store that must not land.
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom, $urandom,
            5'($urandom_range(0, 31)));
      @(negedge clk);
    end
    drive(2'b11, 3'b001, 32'h20, 32'h77, 5'd9);
    tick();
    chk_regs("rst_hold", 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);

    bus.memEX = 3'b100;
    bus.zFlag = 1'b1;
    bus.brDst = 32'h1234;
    #1;
    chk("rst_pcSrc", {31'd0, bus.pcSrc}, 32'd1);
    chk("rst_brTgt", bus.brTgt, 32'h1234);

    @(negedge clk);
    rst = 1'b0;
    bus.zFlag = 1'b0;

    // Store suppressed during reset: word 8 still zero.
    drive(2'b00, 3'b010, 32'h20, 32'h0, 5'd0);
    tick();
    chk_regs("rst_nostore", 1'b0, 2'b00, 32'h0, 32'h20, 5'd0);

    // Store then load at 0x10.
    drive(2'b00, 3'b001, 32'h10, 32'hDEADBEEF, 5'd0);
    tick();
    chk_regs("store", 1'b0, 2'b00, 32'h0, 32'h10, 5'd0);
    drive(2'b11, 3'b010, 32'h10, 32'h0, 5'd4);
    tick();
    chk_regs("load", 1'b0, 2'b11, 32'hDEADBEEF, 32'h10, 5'd4);

    // Branch resolution is combinational.
    drive(2'b00, 3'b100, 32'h0, 32'h0, 5'd0);
    bus.brDst = 32'h40;
    bus.zFlag = 1'b1;
    #1;
    chk("br_taken", {31'd0, bus.pcSrc}, 32'd1);
    chk("br_tgt", bus.brTgt, 32'h40);
    bus.zFlag = 1'b0;
    #1;
    chk("br_zf0", {31'd0, bus.pcSrc}, 32'd0);
    bus.memEX = 3'b000;
    bus.zFlag = 1'b1;
    #1;
    chk("br_nobranch", {31'd0, bus.pcSrc}, 32'd0);
    bus.zFlag = 1'b0;

    // Misaligned store suppressed; flag for exactly one cycle.
    drive(2'b00, 3'b001, 32'h13, 32'h5, 5'd0);
    tick();
    chk_regs("mis_store", 1'b1, 2'b00, 32'h0, 32'h13, 5'd0);
    drive(2'b00, 3'b010, 32'h10, 32'h0, 5'd0);
    tick();
    chk_regs("mis_check", 1'b0, 2'b00, 32'hDEADBEEF, 32'h10, 5'd0);
    drive(2'b00, 3'b010, 32'h12, 32'h0, 5'd0);
    tick();
    chk_regs("mis_load", 1'b1, 2'b00, 32'h0, 32'h12, 5'd0);
    drive(2'b00, 3'b000, 32'h11, 32'h0, 5'd0);
    tick();
    chk("mis_noaccess", {31'd0, bus.alignErr}, 32'd0);

    // Address wrap and read-during-write.
    drive(2'b00, 3'b001, 32'h400, 32'hA5, 5'd0);
    tick();
    drive(2'b00, 3'b010, 32'h0, 32'h0, 5'd0);
    tick();
    chk("wrap_load", bus.rdData, 32'hA5);
    drive(2'b00, 3'b011, 32'h0, 32'h1, 5'd0);
    tick();
    chk("rdw_old", bus.rdData, 32'hA5);
    drive(2'b00, 3'b010, 32'h0, 32'h0, 5'd0);
    tick();
    chk("rdw_new", bus.rdData, 32'h1);

    // Passthrough with no memory access.
    drive(2'b10, 3'b000, 32'h10, 32'h0, 5'd31);
    tick();
    chk_regs("pass", 1'b0, 2'b10, 32'h0, 32'h10, 5'd31);

    // Asynchronous reset mid-cycle after a nonzero capture.
    drive(2'b11, 3'b010, 32'h10, 32'h0, 5'd7);
    tick();
    chk_regs("pre_arst", 1'b0, 2'b11, 32'hDEADBEEF, 32'h10, 5'd7);
    #2;
    rst = 1'b1;
    #1;
    chk_regs("arst", 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_regs("post_arst", 1'b0, 2'b11, 32'hDEADBEEF, 32'h10, 5'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline, directly downstream of the EX stage. Consumes the EX/MEM signals (control bits, branch target, zero flag, ALU result, store data, destination register), resolves the branch decision, performs data-memory reads and writes, and registers the MEM/WB pipeline latch for write-back.

## Interface
Parameters:
- AW, 8, data-memory word-address width (depth = 2^AW 32-bit words)

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- wbEX  in  2  WB control from EX: [1] regwrite, [0] memtoreg
- memEX  in  3  MEM control from EX: [2] branch, [1] memread, [0] memwrite
- brDst  in  32  branch target computed in EX
- zFlag  in  1  ALU zero flag
- alu_out  in  32  ALU result; the byte address for loads and stores
- rtEX  in  32  store data
- wrDstEX  in  5  destination register number
- pcSrc  out  1  take-branch select to IF (combinational)
- brTgt  out  32  branch target to IF (combinational, equals brDst)
- alignErr  out  1  registered: last access had alu_out[1:0] != 0
- wbMEM  out  2  registered WB control
- rdData  out  32  registered load data
- aluMEM  out  32  registered ALU result
- wrDstMEM  out  5  registered destination register

## Operation
- Branch: pcSrc = memEX[2] & zFlag; brTgt = brDst. No state involved.
- Word index = alu_out[AW+1:2]; upper address bits are ignored (addresses wrap modulo 2^(AW+2)).
- Misaligned: alu_out[1:0] != 0 while memread or memwrite. The store is suppressed, the load returns 0, and alignErr is 1 on the following cycle. alignErr is 0 when neither memread nor memwrite is set.
- Store: memwrite=1 and aligned and rst=0 writes rtEX to mem[index] at the rising edge.
- Load: memread=1 and aligned reads mem[index] asynchronously, and the value is captured into rdData at the edge. When memread=0, rdData captures 0.
- memread and memwrite both set on the same address: the read returns the pre-write contents, and the new value is visible from the next cycle.
- MEM/WB latch captures wbEX, alu_out, and wrDstEX every edge; there is no stall or flush input.
- Memory contents are not affected by rst and are zero at time 0 in simulation.
- Reset values: wbMEM=0, rdData=0, aluMEM=0, wrDstMEM=0, alignErr=0. pcSrc and brTgt follow their inputs even during reset.

## Timing
- pcSrc and brTgt: same cycle, combinational from the inputs.
- wbMEM, rdData, aluMEM, wrDstMEM, alignErr: one-cycle latency; inputs sampled at edge N appear after edge N.
- Store-to-load on consecutive cycles, same address: the load sees the new data (the write lands at edge N, the read happens in cycle N+1).
- rst asserted mid-cycle clears the registered outputs immediately (asynchronously). A store pending at an edge where rst=1 is not performed.
- rst deassertion: the first capture occurs at the next rising edge.

## Structure
- Shared package: bit-position constants MEM_BRANCH=2, MEM_READ=1, MEM_WRITE=0, WB_REGWRITE=1, WB_MEMTOREG=0. EX, MEM and WB all use these constants.
- One sub-module: data_mem (parameter AW; clk, we, addr, wdata, rdata; synchronous write, asynchronous read, no reset).
- mem_stage contains the branch logic, alignment check, and MEM/WB registers.

## Test plan
- Reset: hold rst=1 with random inputs → all registered outputs 0. Assert rst mid-cycle → outputs clear without a clock edge.
- Store then load: memEX=3'b001, alu_out=32'h10, rtEX=32'hDEADBEEF. Next cycle memEX=3'b010, same address → one cycle later rdData=32'hDEADBEEF, aluMEM=32'h10.
- Branch: memEX=3'b100, zFlag=1, brDst=32'h40 → pcSrc=1, brTgt=32'h40 in the same cycle. With zFlag=0 → pcSrc=0.
- Misaligned: memwrite with alu_out=32'h13, rtEX=32'h5 → alignErr=1 next cycle. A load from word 4 (alu_out=32'h10) still returns the earlier value, confirming the store was suppressed.
- Wrap and simultaneous access (AW=8): store 32'hA5 at alu_out=32'h400 → load from alu_out=32'h0 returns 32'hA5. memread and memwrite both set with new data 32'h1 → rdData=32'hA5; the next load returns 32'h1.
- Passthrough: wbEX=2'b10, wrDstEX=5'd31, memEX=0 → after one edge wbMEM=2'b10, wrDstMEM=31, rdData=0.
